alu_share_arbiter: RTL and testbench

- Shares one combinational ALU (a, b, 3-bit alu_control, result, zero) between two requesters.
- Uses round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Latches the granted operands, holds them on the ALU for a fixed number of cycles, registers result/zero, and returns them to the owning requester.
- Sits between the execute-stage issue logic and the shared ALU instance.

---
 rtl/alu_share_arbiter.sv | 169 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin sharing of one combinational ALU between two
//            requesters. The granted operands are latched and held on the ALU
//            for EXEC_CYCLES cycles. The result and zero flag are then
//            registered and returned to the owning requester through a
//            valid/ready response port.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_W      = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,

    output logic              busy
);

    // The hold counter is two bits wide, so at most four execute cycles fit
    generate
        if (EXEC_CYCLES < 1 || EXEC_CYCLES > 4) begin : g_bad_exec_cycles
            $error("alu_share_arbiter: EXEC_CYCLES must be in 1..4");
        end
    endgenerate

    localparam logic [1:0] C_EXEC_LOAD = 2'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state_q;
    logic              r_last_grant_q;
    logic              r_owner_q;
    logic [1:0]        r_cnt_q;
    logic [DATA_W-1:0] r_alu_a_q;
    logic [DATA_W-1:0] r_alu_b_q;
    logic [2:0]        r_alu_op_q;
    logic              r_rsp0_valid_q;
    logic              r_rsp1_valid_q;
    logic [DATA_W-1:0] r_rsp0_result_q;
    logic [DATA_W-1:0] r_rsp1_result_q;
    logic              r_rsp0_zero_q;
    logic              r_rsp1_zero_q;

    logic w_idle;
    logic w_sel0;
    logic w_sel1;
    logic w_hs0;
    logic w_hs1;
    logic w_rsp_hs;

    // Round-robin pick: a lone requester wins; on contention the one not granted last wins
    assign w_idle   = (r_state_q == ST_IDLE);
    assign w_sel0   = req0_valid && (!req1_valid || r_last_grant_q);
    assign w_sel1   = req1_valid && (!req0_valid || !r_last_grant_q);

    // Ready is forced low while reset is asserted so no output shows a grant during reset
    assign req0_ready = rst_n && w_idle && w_sel0;
    assign req1_ready = rst_n && w_idle && w_sel1;

    assign w_hs0    = req0_valid && req0_ready;
    assign w_hs1    = req1_valid && req1_ready;
    assign w_rsp_hs = (r_rsp0_valid_q && rsp0_ready) || (r_rsp1_valid_q && rsp1_ready);

    // Grant, hold operands for EXEC_CYCLES, capture the result, wait for the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q       <= ST_IDLE;
            r_last_grant_q  <= 1'b1;
            r_owner_q       <= 1'b0;
            r_cnt_q         <= 2'd0;
            r_alu_a_q       <= '0;
            r_alu_b_q       <= '0;
            r_alu_op_q      <= 3'd0;
            r_rsp0_valid_q  <= 1'b0;
            r_rsp1_valid_q  <= 1'b0;
            r_rsp0_result_q <= '0;
            r_rsp1_result_q <= '0;
            r_rsp0_zero_q   <= 1'b0;
            r_rsp1_zero_q   <= 1'b0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    if (w_hs0 || w_hs1) begin
                        r_owner_q      <= w_hs1;
                        r_last_grant_q <= w_hs1;
                        r_alu_a_q      <= w_hs1 ? req1_a  : req0_a;
                        r_alu_b_q      <= w_hs1 ? req1_b  : req0_b;
                        r_alu_op_q     <= w_hs1 ? req1_op : req0_op;
                        r_cnt_q        <= C_EXEC_LOAD;
                        r_state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt_q == 2'd0) begin
                        if (r_owner_q) begin
                            r_rsp1_result_q <= alu_result;
                            r_rsp1_zero_q   <= alu_zero;
                            r_rsp1_valid_q  <= 1'b1;
                        end else begin
                            r_rsp0_result_q <= alu_result;
                            r_rsp0_zero_q   <= alu_zero;
                            r_rsp0_valid_q  <= 1'b1;
                        end
                        r_state_q <= ST_RESP;
                    end else begin
                        r_cnt_q <= r_cnt_q - 2'd1;
                    end
                end
                ST_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp0_valid_q <= 1'b0;
                        r_rsp1_valid_q <= 1'b0;
                        r_state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_a       = r_alu_a_q;
    assign alu_b       = r_alu_b_q;
    assign alu_control = r_alu_op_q;
    assign rsp0_valid  = r_rsp0_valid_q;
    assign rsp1_valid  = r_rsp1_valid_q;
    assign rsp0_result = r_rsp0_result_q;
    assign rsp1_result = r_rsp1_result_q;
    assign rsp0_zero   = r_rsp0_zero_q;
    assign rsp1_zero   = r_rsp1_zero_q;
    assign busy        = (r_state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Self-checking bench for alu_share_arbiter. It provides a
//            behavioural ALU and a transaction-level reference model, and
//            runs directed scenarios followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int DW  = 32;
    localparam int EC  = 1;
    localparam int EC3 = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;

    // Main DUT (EXEC_CYCLES = 1)
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]    req0_op, req1_op;
    logic          rsp0_valid, rsp0_ready, rsp0_zero;
    logic          rsp1_valid, rsp1_ready, rsp1_zero;
    logic [DW-1:0] rsp0_result, rsp1_result;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [2:0]    alu_control;
    logic          alu_zero, busy;

    // Second DUT (EXEC_CYCLES = 3)
    logic          t3_req0_valid, t3_req0_ready, t3_req1_ready;
    logic [DW-1:0] t3_req0_a, t3_req0_b;
    logic [2:0]    t3_req0_op;
    logic          t3_rsp0_valid, t3_rsp0_ready, t3_rsp0_zero;
    logic          t3_rsp1_valid, t3_rsp1_zero;
    logic [DW-1:0] t3_rsp0_result, t3_rsp1_result;
    logic [DW-1:0] t3_alu_a, t3_alu_b, t3_alu_result;
    logic [2:0]    t3_alu_control;
    logic          t3_alu_zero, t3_busy;

    int checks = 0;
    int errors = 0;

    // Reference model state (transaction level)
    bit            m_busy;
    int            m_owner;
    bit            m_last;
    logic [DW-1:0] m_a, m_b;
    logic [2:0]    m_op;
    int            m_rsp_at;
    int            cyc;
    logic [DW-1:0] h_res [2];
    logic          h_zero[2];
    int            grants[$];

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a ^ b;
            3'b100:  return ~(a | b);
            3'b101:  return a << b[4:0];
            3'b110:  return a | b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // External ALUs feeding both DUTs
    always_comb begin
        alu_result    = alu_ref(alu_a, alu_b, alu_control);
        alu_zero      = (alu_result == '0);
        t3_alu_result = alu_ref(t3_alu_a, t3_alu_b, t3_alu_control);
        t3_alu_zero   = (t3_alu_result == '0);
    end

    alu_share_arbiter #(.DATA_W(DW), .EXEC_CYCLES(EC)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    alu_share_arbiter #(.DATA_W(DW), .EXEC_CYCLES(EC3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(t3_req0_valid), .req0_ready(t3_req0_ready), .req0_a(t3_req0_a), .req0_b(t3_req0_b),
        .req0_op(t3_req0_op),
        .req1_valid(1'b0), .req1_ready(t3_req1_ready), .req1_a('0), .req1_b('0), .req1_op(3'd0),
        .rsp0_valid(t3_rsp0_valid), .rsp0_ready(t3_rsp0_ready), .rsp0_result(t3_rsp0_result),
        .rsp0_zero(t3_rsp0_zero),
        .rsp1_valid(t3_rsp1_valid), .rsp1_ready(1'b1), .rsp1_result(t3_rsp1_result), .rsp1_zero(t3_rsp1_zero),
        .alu_a(t3_alu_a), .alu_b(t3_alu_b), .alu_control(t3_alu_control),
        .alu_result(t3_alu_result), .alu_zero(t3_alu_zero), .busy(t3_busy)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy    = 1'b0;
        m_owner   = 0;
        m_last    = 1'b1;
        m_a       = '0;
        m_b       = '0;
        m_op      = 3'd0;
        m_rsp_at  = 0;
        cyc       = 0;
        h_res[0]  = '0;
        h_res[1]  = '0;
        h_zero[0] = 1'b0;
        h_zero[1] = 1'b0;
    endtask

    // Called at a falling edge after inputs are set: check all outputs, advance the model, wait a cycle
    task automatic tick();
        logic          e_r0, e_r1, e_v0, e_v1;
        logic [DW-1:0] r;
        #1;
        if (m_busy && cyc == m_rsp_at) begin
            r               = alu_ref(m_a, m_b, m_op);
            h_res[m_owner]  = r;
            h_zero[m_owner] = (r == '0);
        end
        e_r0 = rst_n && !m_busy && req0_valid && (!req1_valid || m_last);
        e_r1 = rst_n && !m_busy && req1_valid && (!req0_valid || !m_last);
        e_v0 = m_busy && (cyc >= m_rsp_at) && (m_owner == 0);
        e_v1 = m_busy && (cyc >= m_rsp_at) && (m_owner == 1);
        chk("req0_ready",  DW'(req0_ready),  DW'(e_r0));
        chk("req1_ready",  DW'(req1_ready),  DW'(e_r1));
        chk("ready_excl",  DW'(req0_ready & req1_ready), '0);
        chk("rsp0_valid",  DW'(rsp0_valid),  DW'(e_v0));
        chk("rsp1_valid",  DW'(rsp1_valid),  DW'(e_v1));
        chk("rsp0_result", rsp0_result,      h_res[0]);
        chk("rsp0_zero",   DW'(rsp0_zero),   DW'(h_zero[0]));
        chk("rsp1_result", rsp1_result,      h_res[1]);
        chk("rsp1_zero",   DW'(rsp1_zero),   DW'(h_zero[1]));
        chk("alu_a",       alu_a,            m_a);
        chk("alu_b",       alu_b,            m_b);
        chk("alu_control", DW'(alu_control), DW'(m_op));
        chk("busy",        DW'(busy),        DW'(m_busy));
        if (rst_n) begin
            if (e_r0 || e_r1) begin
                m_owner  = e_r1 ? 1 : 0;
                m_last   = e_r1;
                m_a      = e_r1 ? req1_a  : req0_a;
                m_b      = e_r1 ? req1_b  : req0_b;
                m_op     = e_r1 ? req1_op : req0_op;
                m_busy   = 1'b1;
                m_rsp_at = cyc + 1 + EC;
                grants.push_back(m_owner);
            end else if ((e_v0 && rsp0_ready) || (e_v1 && rsp1_ready)) begin
                m_busy = 1'b0;
            end
            cyc++;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 3'd0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 3'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    // Asynchronous reset pulse starting at a falling edge
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        t3_req0_valid = 1'b0; t3_req0_a = '0; t3_req0_b = '0; t3_req0_op = 3'd0; t3_rsp0_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Single request from requester 0: 5 + 7
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 3'b000; rsp0_ready = 1'b1;
        #1 chk("plan1_ready0", DW'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        repeat (3) tick();
        chk("plan1_result", rsp0_result, 32'd12);

        // Both requesters always valid from reset: alternating grants
        do_reset();
        grants.delete();
        req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req0_a = 32'(100 + i); req0_b = 32'(i);
            req1_a = 32'(200 + i); req1_b = 32'(2 * i);
            tick();
        end
        chk("rr_count_ge4", DW'(grants.size() >= 4), 32'd1);
        if (grants.size() >= 4) begin
            chk("rr_grant0", DW'(grants[0]), 32'd0);
            chk("rr_grant1", DW'(grants[1]), 32'd1);
            chk("rr_grant2", DW'(grants[2]), 32'd0);
            chk("rr_grant3", DW'(grants[3]), 32'd1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) tick();

        // Requester 1: 9 - 9 gives zero
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_op = 3'b001;
        tick();
        req1_valid = 1'b0;
        repeat (3) tick();
        chk("plan3_result", rsp1_result, 32'd0);
        chk("plan3_zero",   DW'(rsp1_zero), 32'd1);

        // Backpressure on response 0 with requester 1 waiting
        req0_valid = 1'b1; req0_a = 32'hF0; req0_b = 32'h0F; req0_op = 3'b110;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 3'b000;
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        tick();
        req0_valid = 1'b0;
        repeat (EC + 5) tick();
        chk("plan4_held_valid",  DW'(rsp0_valid), 32'd1);
        chk("plan4_held_result", rsp0_result, 32'hFF);
        rsp0_ready = 1'b1;
        tick();
        chk("plan4_idle_grant1", DW'(req1_ready), 32'd1);
        req1_valid = 1'b0;
        repeat (4) tick();

        // Reset while in EXEC discards the operation
        req0_valid = 1'b1; req0_a = 32'h1234; req0_b = 32'h1; req0_op = 3'b000;
        tick();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",   DW'(busy), 32'd0);
        chk("midrst_alu_a",  alu_a, 32'd0);
        chk("midrst_result", rsp0_result, 32'd0);
        chk("midrst_valid",  DW'(rsp0_valid | rsp1_valid), 32'd0);
        @(negedge clk);
        model_reset();
        clear_inputs();
        tick();
        rst_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_a = 32'd3; req1_a = 32'd4;
        #1 chk("postrst_grant0", DW'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) tick();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req0_b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req1_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req1_b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req0_op = 3'($urandom_range(0, 7));
            req1_op = 3'($urandom_range(0, 7));
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // EXEC_CYCLES = 3 instance: 3 < 10 via op 111
        t3_req0_valid = 1'b1; t3_req0_a = 32'd3; t3_req0_b = 32'd10; t3_req0_op = 3'b111; t3_rsp0_ready = 1'b1;
        #1 chk("ec3_ready", DW'(t3_req0_ready), 32'd1);
        @(negedge clk);
        t3_req0_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("ec3_alu_a",   t3_alu_a, 32'd3);
            chk("ec3_alu_b",   t3_alu_b, 32'd10);
            chk("ec3_alu_ctl", DW'(t3_alu_control), 32'd7);
            chk("ec3_busy",    DW'(t3_busy), 32'd1);
            chk("ec3_rsp_valid", DW'(t3_rsp0_valid), (k == 3) ? 32'd1 : 32'd0);
            chk("ec3_rsp1_valid", DW'(t3_rsp1_valid), 32'd0);
            @(negedge clk);
        end
        #1;
        chk("ec3_result",    t3_rsp0_result, 32'd1);
        chk("ec3_zero",      DW'(t3_rsp0_zero), 32'd0);
        chk("ec3_idle",      DW'(t3_busy), 32'd0);
        chk("ec3_valid_off", DW'(t3_rsp0_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
